nbit_restoring_divider: RTL and testbench

- Sequential N-bit unsigned restoring divider, one quotient bit per clock.
- Does not contain a subtractor. It drives an external combinational N-bit subtractor through the sub_a/sub_b ports and consumes its result and flags in the same cycle, so it sits both upstream and downstream of that stage.
- Produces registered quotient, remainder and a 4-bit flag vector for the lab ALU/display path.

---
 rtl/nbit_restoring_divider_pkg.sv | 32 +++
 rtl/nbit_restoring_divider_sub.sv | 33 +++
 rtl/nbit_restoring_divider.sv | 147 ++++++++++++++
 tb/tb_nbit_restoring_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/nbit_restoring_divider_pkg.sv
// rtl/nbit_restoring_divider_pkg.sv - shared types and constants for the restoring divider
//
// Purpose: FSM state encoding, result flag bit positions, the subtractor flag
// position the divider consumes, and a helper that assembles the result flags.

package nbit_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Result flag vector bit positions (bit 3 is reserved and always 0)
    localparam int FLAG_Z   = 0;  // quotient == 0
    localparam int FLAG_DZ  = 1;  // divide by zero
    localparam int FLAG_RNZ = 2;  // remainder != 0

    // External subtractor flag bit positions
    localparam int SUB_ZERO   = 0;
    localparam int SUB_BORROW = 2;

    function automatic logic [3:0] pack_flags(input logic qz, input logic dz, input logic rnz);
        logic [3:0] f;
        f           = 4'b0000;
        f[FLAG_Z]   = qz;
        f[FLAG_DZ]  = dz;
        f[FLAG_RNZ] = rnz;
        return f;
    endfunction

endpackage

// File: rtl/nbit_restoring_divider_sub.sv
// rtl/nbit_restoring_divider_sub.sv - combinational N-bit subtractor paired with the divider
//
// Purpose: result = a - b mod 2^N with status flags, wired beside the divider
// by the parent.
// Ports:
//   a, b    : N-bit minuend / subtrahend
//   result  : a - b mod 2^N
//   flags   : [0] result zero, [1] result MSB, [2] borrow out, [3] signed overflow

import nbit_restoring_divider_pkg::*;

module nbit_restoring_divider_sub #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    logic [N:0] diff;

    always_comb begin
        diff              = {1'b0, a} - {1'b0, b};
        result            = diff[N-1:0];
        flags             = 4'b0000;
        flags[SUB_ZERO]   = (diff[N-1:0] == '0);
        flags[1]          = diff[N-1];
        flags[SUB_BORROW] = diff[N];
        flags[3]          = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
    end

endmodule

// File: rtl/nbit_restoring_divider.sv
// rtl/nbit_restoring_divider.sv - sequential N-bit unsigned restoring divider
//
// Purpose: one quotient bit per clock using an external combinational
// subtractor driven through sub_a/sub_b and read back the same cycle.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a division (honoured only when idle)
//   dividend, divisor    : operands, sampled with start
//   sub_a, sub_b         : operands to the external subtractor (0 when not iterating)
//   sub_result, sub_flags: subtractor difference and flags (bit2 = borrow)
//   busy                 : high while iterating
//   done                 : one-cycle completion pulse
//   quotient, remainder  : registered results, held until next completion
//   flags                : [0] q==0, [1] div-by-zero, [2] r!=0, [3] 0

import nbit_restoring_divider_pkg::*;

module nbit_restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] sub_a,
    output logic [N-1:0] sub_b,
    input  logic [N-1:0] sub_result,
    input  logic [3:0]   sub_flags,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic [3:0]   flags
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    div_state_t    state_q, state_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quot_d, rem_d;
    logic [3:0]    flags_d;
    logic [N-1:0]  shifted;
    logic          accept;

    // Only the borrow bit steers the algorithm; the others are unused here.
    logic unused_sub_flags;
    assign unused_sub_flags = ^{sub_flags[3], sub_flags[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            count_q   <= '0;
            quotient  <= '0;
            remainder <= '0;
            flags     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            count_q   <= count_d;
            quotient  <= quot_d;
            remainder <= rem_d;
            flags     <= flags_d;
        end
    end

    // Before the final shift the partial remainder holds at most N-1
    // significant bits, so the N-bit subtractor never loses a carry.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RUN) begin
            assert (r_q[N-1] == 1'b0)
                else $error("partial remainder MSB set during iteration");
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        count_d = count_q;
        quot_d  = quotient;
        rem_d   = remainder;
        flags_d = flags;
        sub_a   = '0;
        sub_b   = '0;
        shifted = '0;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        count_d = CW'(N - 1);
                        state_d = RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        flags_d = pack_flags(1'b0, 1'b1, dividend != '0);
                        state_d = DONE;
                    end
                end
            end

            RUN: begin
                // Bring the next dividend bit into the partial remainder and
                // keep the difference only if no borrow occurred.
                shifted = {r_q[N-2:0], q_q[N-1]};
                sub_a   = shifted;
                sub_b   = d_q;
                accept  = ~sub_flags[SUB_BORROW];
                r_d     = accept ? sub_result : shifted;
                q_d     = {q_q[N-2:0], accept};
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    flags_d = pack_flags(q_d == '0, 1'b0, r_d != '0);
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_nbit_restoring_divider.sv
// tb/tb_nbit_restoring_divider.sv - scoreboard bench for the restoring divider and its subtractor

module tb_nbit_restoring_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] sub_a, sub_b, sub_result;
    logic [3:0]   sub_flags;
    logic         busy, done;
    logic [N-1:0] quotient, remainder;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    nbit_restoring_divider #(.N(N)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_result (sub_result),
        .sub_flags  (sub_flags),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .flags      (flags)
    );

    nbit_restoring_divider_sub #(.N(N)) u_sub (
        .a      (sub_a),
        .b      (sub_b),
        .result (sub_result),
        .flags  (sub_flags)
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic [3:0]   f;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   exp_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = N'(a);
            e.f = 4'b0010 | ((a != 0) ? 4'b0100 : 4'b0000);
        end else begin
            e.q = N'(a / b);
            e.r = N'(a % b);
            e.f = {1'b0, (a % b) != 0, 1'b0, (a / b) == 0};
        end
        return e;
    endfunction

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("flags", 32'(flags), 32'(e.f));
            end
        end
    end

    task automatic run_div(input int a, input int b);
        int cyc;
        int busy_cyc;
        sb.push_back(model(a, b));
        exp_done++;
        @(negedge clk);
        start    = 1'b1;
        dividend = N'(a);
        divisor  = N'(b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        cyc      = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
        end while (!done && cyc < 30);
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        check("latency", 32'(cyc), (b == 0) ? 32'd1 : 32'(N + 1));
        check("busy_cycles", 32'(busy_cyc), (b == 0) ? 32'd0 : 32'(N));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_sub_a", 32'(sub_a), 32'd0);
        check("idle_sub_b", 32'(sub_b), 32'd0);

        run_div(13, 3);
        run_div(2, 7);
        run_div(15, 1);
        run_div(9, 0);
        run_div(0, 0);

        // Start pulses during RUN and DONE must be ignored
        sb.push_back(model(13, 3));
        exp_done++;
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        check("run_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 20);
        check("ign_reached_done", 32'(done), 32'd1);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_quotient", 32'(quotient), 32'd4);
        check("ign_remainder", 32'(remainder), 32'd1);

        // Reset during the third RUN cycle abandons the operation
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_quotient", 32'(quotient), 32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        check("mid_rst_flags", 32'(flags), 32'd0);
        check("mid_rst_sub_a", 32'(sub_a), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        run_div(12, 4);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a, b);
            end
        end

        repeat (4) @(negedge clk);
        check("done_count", 32'(n_done), 32'(exp_done));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
